// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, drives the ROM port and registers the IF/ID word.
// Optional misaligned-target redirect is enabled by defining FETCH_ALIGN_CHECK_EN.

`ifndef CHIP_ENABLE
`define CHIP_ENABLE 1'b1
`endif
`ifndef CHIP_DISABLE
`define CHIP_DISABLE 1'b0
`endif

module inst_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    input  logic        flush_i,
    input  logic [31:0] new_pc_i,
    output logic [31:0] rom_addr_o,
    output logic        rom_ce_o,
    input  logic [31:0] rom_data_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        if_valid_o,
    output logic        fetch_err_o
);

`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        ce_q, ce_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic        if_valid_q, if_valid_d;
    logic        pend_vld_q, pend_vld_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic        err_q, err_d;

    logic        tgt_used;
    logic [31:0] next_pc;

    // A branch seen during a stall takes precedence over the live branch input.
    assign tgt_used = pend_vld_q | branch_flag_i;
    assign next_pc  = pend_vld_q    ? pend_tgt_q :
                      branch_flag_i ? branch_target_i :
                                      pc_q + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            ce_q       <= `CHIP_DISABLE;
            if_pc_q    <= 32'h0;
            if_inst_q  <= 32'h0;
            if_valid_q <= 1'b0;
            pend_vld_q <= 1'b0;
            pend_tgt_q <= 32'h0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ce_q       <= ce_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
            if_valid_q <= if_valid_d;
            pend_vld_q <= pend_vld_d;
            pend_tgt_q <= pend_tgt_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ce_d       = ce_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;
        if_valid_d = if_valid_q;
        pend_vld_d = pend_vld_q;
        pend_tgt_d = pend_tgt_q;
        err_d      = 1'b0;

        if (flush_i) begin
            pc_d       = new_pc_i;
            if_valid_d = 1'b0;
            if_inst_d  = 32'h0;
            pend_vld_d = 1'b0;
            state_d    = S_FETCH;
            ce_d       = `CHIP_ENABLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_FETCH;
                    ce_d    = `CHIP_ENABLE;
                end
                default: begin
                    if (stall_i) begin
                        state_d = S_HOLD;
                        if (branch_flag_i) begin
                            pend_vld_d = 1'b1;
                            pend_tgt_d = branch_target_i;
                        end
                    end else begin
                        // The word at the current pc is the delay slot and is always captured.
                        if_inst_d  = rom_data_i;
                        if_pc_d    = pc_q;
                        if_valid_d = 1'b1;
                        pc_d       = next_pc;
                        pend_vld_d = 1'b0;
                        state_d    = S_FETCH;
                        if (ALIGN_CHECK && tgt_used && (next_pc[1:0] != 2'b00)) begin
                            pc_d  = EXC_VECTOR;
                            err_d = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign rom_addr_o  = pc_q;
    assign rom_ce_o    = ce_q;
    assign if_pc_o     = if_pc_q;
    assign if_inst_o   = if_inst_q;
    assign if_valid_o  = if_valid_q;
    assign fetch_err_o = err_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl with a small combinational ROM model attached.
module tb_inst_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch = 1'b0;
    logic [31:0] tgt = 32'h0;
    logic        flush = 1'b0;
    logic [31:0] new_pc = 32'h0;
    logic [31:0] rom_addr, if_pc, if_inst, rom_data;
    logic        rom_ce, if_valid, fetch_err;

    logic        w_rst = 1'b1;
    logic [31:0] w_rom_addr, w_if_pc, w_if_inst, w_rom_data;
    logic        w_rom_ce, w_if_valid, w_fetch_err;

    logic [31:0] rom [16];
    int checks = 0;
    int errors = 0;

    // snapshot layout: {ce, valid, err, if_pc, if_inst, rom_addr}
    logic [98:0] snap, w_snap;

    always #5 clk = ~clk;

    assign rom_data   = rom[rom_addr[5:2]];
    assign w_rom_data = rom[w_rom_addr[5:2]];
    assign snap   = {rom_ce, if_valid, fetch_err, if_pc, if_inst, rom_addr};
    assign w_snap = {w_rom_ce, w_if_valid, w_fetch_err, w_if_pc, w_if_inst, w_rom_addr};

    inst_fetch_ctrl u_dut (
        .clk(clk), .rst(rst), .stall_i(stall), .branch_flag_i(branch),
        .branch_target_i(tgt), .flush_i(flush), .new_pc_i(new_pc),
        .rom_addr_o(rom_addr), .rom_ce_o(rom_ce), .rom_data_i(rom_data),
        .if_pc_o(if_pc), .if_inst_o(if_inst), .if_valid_o(if_valid),
        .fetch_err_o(fetch_err)
    );

    inst_fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(w_rst), .stall_i(1'b0), .branch_flag_i(1'b0),
        .branch_target_i(32'h0), .flush_i(1'b0), .new_pc_i(32'h0),
        .rom_addr_o(w_rom_addr), .rom_ce_o(w_rom_ce), .rom_data_i(w_rom_data),
        .if_pc_o(w_if_pc), .if_inst_o(w_if_inst), .if_valid_o(w_if_valid),
        .fetch_err_o(w_fetch_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [98:0] exp;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        exp = {1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0};
        checks++;
        if (snap !== exp) begin errors++; $display("FAIL reset_state got %h want %h", snap, exp); end
        else $display("reset_state ok %h", snap);
        step();
        exp = {1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0};
        checks++;
        if (snap !== exp) begin errors++; $display("FAIL idle_to_fetch got %h want %h", snap, exp); end
        else $display("idle_to_fetch ok %h", snap);
    endtask

    task automatic test_sequential();
        logic [98:0] exp;
        step();
        exp = {1'b1, 1'b1, 1'b0, 32'h0, 32'h34011100, 32'h4};
        checks++;
        if (snap !== exp) begin errors++; $display("FAIL seq_word0 got %h want %h", snap, exp); end
        else $display("seq_word0 ok %h", snap);
        step();
        exp = {1'b1, 1'b1, 1'b0, 32'h4, 32'h34020020, 32'h8};
        checks++;
        if (snap !== exp) begin errors++; $display("FAIL seq_word1 got %h want %h", snap, exp); end
        else $display("seq_word1 ok %h", snap);
    endtask

    task automatic test_stall();
        logic [98:0] exp;
        stall = 1'b1;
        exp = {1'b1, 1'b1, 1'b0, 32'h4, 32'h34020020, 32'h8};
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (snap !== exp) begin errors++; $display("FAIL stall_hold%0d got %h want %h", i, snap, exp); end
            else $display("stall_hold%0d ok %h", i, snap);
        end
        stall = 1'b0;
        step();
        exp = {1'b1, 1'b1, 1'b0, 32'h8, 32'h3403FF00, 32'hC};
        checks++;
        if (snap !== exp) begin errors++; $display("FAIL stall_release got %h want %h", snap, exp); end
        else $display("stall_release ok %h", snap);
        step();
        exp = {1'b1, 1'b1, 1'b0, 32'hC, 32'h3404FFFF, 32'h10};
        checks++;
        if (snap !== exp) begin errors++; $display("FAIL seq_word3 got %h want %h", snap, exp); end
        else $display("seq_word3 ok %h", snap);
    endtask

    task automatic test_branch();
        logic [98:0] exp;
        flush = 1'b1; new_pc = 32'h4;
        step();
        flush = 1'b0;
        exp = {1'b1, 1'b0, 1'b0, 32'hC, 32'h0, 32'h4};
        checks++;
        if (snap !== exp) begin errors++; $display("FAIL branch_setup got %h want %h", snap, exp); end
        else $display("branch_setup ok %h", snap);
        branch = 1'b1; tgt = 32'h0;
        step();
        branch = 1'b0;
        exp = {1'b1, 1'b1, 1'b0, 32'h4, 32'h34020020, 32'h0};
        checks++;
        if (snap !== exp) begin errors++; $display("FAIL branch_delay_slot got %h want %h", snap, exp); end
        else $display("branch_delay_slot ok %h", snap);
        step();
        exp = {1'b1, 1'b1, 1'b0, 32'h0, 32'h34011100, 32'h4};
        checks++;
        if (snap !== exp) begin errors++; $display("FAIL branch_target got %h want %h", snap, exp); end
        else $display("branch_target ok %h", snap);
    endtask

    task automatic test_pending();
        logic [98:0] exp;
        stall = 1'b1; branch = 1'b1; tgt = 32'hC;
        step();
        branch = 1'b0;
        exp = {1'b1, 1'b1, 1'b0, 32'h0, 32'h34011100, 32'h4};
        checks++;
        if (snap !== exp) begin errors++; $display("FAIL pend_hold got %h want %h", snap, exp); end
        else $display("pend_hold ok %h", snap);
        step();
        stall = 1'b0;
        step();
        exp = {1'b1, 1'b1, 1'b0, 32'h4, 32'h34020020, 32'hC};
        checks++;
        if (snap !== exp) begin errors++; $display("FAIL pend_release got %h want %h", snap, exp); end
        else $display("pend_release ok %h", snap);
        step();
        exp = {1'b1, 1'b1, 1'b0, 32'hC, 32'h3404FFFF, 32'h10};
        checks++;
        if (snap !== exp) begin errors++; $display("FAIL pend_cleared got %h want %h", snap, exp); end
        else $display("pend_cleared ok %h", snap);
        stall = 1'b1; branch = 1'b1; tgt = 32'h8;
        step();
        tgt = 32'h0;
        step();
        stall = 1'b0; branch = 1'b0;
        step();
        exp = {1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 32'h0};
        checks++;
        if (snap !== exp) begin errors++; $display("FAIL pend_overwrite got %h want %h", snap, exp); end
        else $display("pend_overwrite ok %h", snap);
    endtask

    task automatic test_flush();
        logic [98:0] exp;
        stall = 1'b1; branch = 1'b1; tgt = 32'h4; flush = 1'b1; new_pc = 32'h8;
        step();
        stall = 1'b0; branch = 1'b0; flush = 1'b0;
        exp = {1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h8};
        checks++;
        if (snap !== exp) begin errors++; $display("FAIL flush_override got %h want %h", snap, exp); end
        else $display("flush_override ok %h", snap);
        step();
        exp = {1'b1, 1'b1, 1'b0, 32'h8, 32'h3403FF00, 32'hC};
        checks++;
        if (snap !== exp) begin errors++; $display("FAIL flush_refetch got %h want %h", snap, exp); end
        else $display("flush_refetch ok %h", snap);
        rst = 1'b1;
        step();
        rst = 1'b0; flush = 1'b1; new_pc = 32'hC;
        step();
        flush = 1'b0;
        exp = {1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'hC};
        checks++;
        if (snap !== exp) begin errors++; $display("FAIL flush_in_idle got %h want %h", snap, exp); end
        else $display("flush_in_idle ok %h", snap);
        step();
        exp = {1'b1, 1'b1, 1'b0, 32'hC, 32'h3404FFFF, 32'h10};
        checks++;
        if (snap !== exp) begin errors++; $display("FAIL flush_idle_fetch got %h want %h", snap, exp); end
        else $display("flush_idle_fetch ok %h", snap);
    endtask

    task automatic test_reset_mid_stall();
        logic [98:0] exp;
        stall = 1'b1; branch = 1'b1; tgt = 32'h4;
        step();
        stall = 1'b0; branch = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        exp = {1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0};
        checks++;
        if (snap !== exp) begin errors++; $display("FAIL rst_mid_stall got %h want %h", snap, exp); end
        else $display("rst_mid_stall ok %h", snap);
        step();
        step();
        exp = {1'b1, 1'b1, 1'b0, 32'h0, 32'h34011100, 32'h4};
        checks++;
        if (snap !== exp) begin errors++; $display("FAIL rst_pending_dropped got %h want %h", snap, exp); end
        else $display("rst_pending_dropped ok %h", snap);
    endtask

    task automatic test_wrap();
        logic [98:0] exp;
        w_rst = 1'b0;
        step();
        exp = {1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFC};
        checks++;
        if (w_snap !== exp) begin errors++; $display("FAIL wrap_start got %h want %h", w_snap, exp); end
        else $display("wrap_start ok %h", w_snap);
        step();
        exp = {1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 32'h0};
        checks++;
        if (w_snap !== exp) begin errors++; $display("FAIL wrap_edge got %h want %h", w_snap, exp); end
        else $display("wrap_edge ok %h", w_snap);
        step();
        exp = {1'b1, 1'b1, 1'b0, 32'h0, 32'h34011100, 32'h4};
        checks++;
        if (w_snap !== exp) begin errors++; $display("FAIL wrap_after got %h want %h", w_snap, exp); end
        else $display("wrap_after ok %h", w_snap);
    endtask

`ifdef FETCH_ALIGN_CHECK_EN
    task automatic test_align();
        logic [98:0] exp;
        branch = 1'b1; tgt = 32'h6;
        step();
        branch = 1'b0;
        exp = {1'b1, 1'b1, 1'b1, 32'h4, 32'h34020020, 32'h20};
        checks++;
        if (snap !== exp) begin errors++; $display("FAIL align_redirect got %h want %h", snap, exp); end
        else $display("align_redirect ok %h", snap);
        step();
        exp = {1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 32'h24};
        checks++;
        if (snap !== exp) begin errors++; $display("FAIL align_pulse_end got %h want %h", snap, exp); end
        else $display("align_pulse_end ok %h", snap);
    endtask
`endif

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 32'h0;
        rom[0]  = 32'h3401_1100;
        rom[1]  = 32'h3402_0020;
        rom[2]  = 32'h3403_FF00;
        rom[3]  = 32'h3404_FFFF;
        rom[15] = 32'hDEAD_BEEF;
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_pending();
        test_flush();
        test_reset_mid_stall();
`ifdef FETCH_ALIGN_CHECK_EN
        test_align();
`endif
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
